sim_run_controller: RTL and testbench
=====================================

Name: sim_run_controller

Overview:
- Run-phase sequencer for the network simulator core.
- Drives the 2-bit run state and the global cycle count, and gates traffic injection and statistics measurement.
- Steps each run through warm-up, measurement and drain phases, then reports completion.
- Sits above the simulator datapath; the datapath reports when the network is empty.

Parameters:
- MAX_CYCLE_WIDTH, 5, width of current_cycle and phase_cycle.
- WARMUP_CYCLES, 4, unpaused cycles spent in WARMUP; 0 skips WARMUP.
- MEASURE_CYCLES, 16, unpaused cycles spent in MEASURE; must be >= 1.
- DRAIN_MAX_CYCLES, 8, unpaused cycle limit in DRAIN before timeout; must be >= 1.
- All counts must fit in MAX_CYCLE_WIDTH bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- pause  in  1  level; freezes state and counters outside IDLE.
- network_empty  in  1  datapath holds no flits; sampled only in DRAIN.
- state  out  2  0=IDLE, 1=WARMUP, 2=MEASURE, 3=DRAIN.
- current_cycle  out  MAX_CYCLE_WIDTH  cycles elapsed in the current/last run.
- phase_cycle  out  MAX_CYCLE_WIDTH  cycles elapsed in the current phase.
- inject_en  out  1  traffic sources may inject.
- measure_en  out  1  statistics counters enabled.
- done  out  1  one-cycle pulse on run completion.
- timeout  out  1  last run ended by drain timeout; sticky until next start.

Behaviour:
- Reset (synchronous, overrides all inputs): state=IDLE; current_cycle, phase_cycle, done and timeout all 0.
- state, current_cycle, phase_cycle, done and timeout are registered.
- inject_en = (state is WARMUP or MEASURE) and !pause.
- measure_en = (state is MEASURE) and !pause.
- "Active edge": an edge where state!=IDLE and pause=0.
  - On each active edge, current_cycle += 1, saturating at all-ones (never wraps).
  - On each active edge, phase_cycle += 1, but it is cleared to 0 on every state change.
- Paused edges outside IDLE: state, current_cycle and phase_cycle hold. network_empty is ignored.
- IDLE:
  - start=1 -> WARMUP (MEASURE if WARMUP_CYCLES=0), with current_cycle=0, phase_cycle=0, timeout=0.
  - pause has no effect in IDLE.
  - current_cycle holds the final value of the last run.
- WARMUP: on the active edge with phase_cycle==WARMUP_CYCLES-1 -> MEASURE.
- MEASURE: on the active edge with phase_cycle==MEASURE_CYCLES-1 -> DRAIN.
- DRAIN exits on an active edge, to IDLE with done=1 for exactly one cycle:
  - network_empty=1 -> IDLE, timeout=0.
  - Else, phase_cycle==DRAIN_MAX_CYCLES-1 -> IDLE, timeout=1.
  - Both true on the same edge -> empty wins, timeout=0.
- start outside IDLE is ignored. start held high across done restarts the run on the first IDLE cycle.
- Reset mid-run aborts immediately to IDLE. No done pulse.

Optional Feature:
- Macro: SIM_DRAIN_TIMEOUT_EN.
- Defined: drain timeout behaves as described above.
- Undefined: DRAIN waits indefinitely for network_empty, and timeout is tied 0.

Test Plan:
- Normal run: reset, pulse start at cycle t.
  - -> state=1 at t+1 with current_cycle=0.
  - -> state=2 when current_cycle=4, inject_en and measure_en both 1.
  - -> state=3 when current_cycle=20, inject_en=0.
  - Assert network_empty at current_cycle 22 -> state=0, current_cycle=23, done pulsed 1 cycle, timeout=0.
- Drain timeout: network_empty held 0.
  - -> DRAIN cycles current_cycle 20..27.
  - -> IDLE with current_cycle=28, done pulse, timeout=1.
  - Next start clears timeout.
- Pause: hold pause 3 cycles in MEASURE at phase_cycle=5.
  - -> phase_cycle stays 5, inject_en=measure_en=0.
  - -> DRAIN entered 3 cycles later than the unpaused run (current_cycle still 20 at entry).
- Saturation: MEASURE_CYCLES=30 -> current_cycle reaches 31 and holds 31 through the end of MEASURE.
- Edge cases:
  - start pulsed during WARMUP -> ignored, run unchanged.
  - reset during MEASURE -> state=0, counters 0, no done.
  - WARMUP_CYCLES=0 -> start goes straight to state=2.
- Macro off: network_empty held 0 for 40 cycles -> remains in DRAIN, timeout=0. Asserting empty -> done pulse.

Source files
------------

// File: rtl/sim_run_controller.sv
// rtl/sim_run_controller.sv - run-phase sequencer: warm-up, measure, drain, done
// SIM_DRAIN_TIMEOUT_EN enables the DRAIN cycle limit; without it DRAIN waits for network_empty.
module sim_run_controller #(
  parameter int MAX_CYCLE_WIDTH  = 5,
  parameter int WARMUP_CYCLES    = 4,
  parameter int MEASURE_CYCLES   = 16,
  parameter int DRAIN_MAX_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       network_empty,
  output logic [1:0]                 state,
  output logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
  output logic [MAX_CYCLE_WIDTH-1:0] phase_cycle,
  output logic                       inject_en,
  output logic                       measure_en,
  output logic                       done,
  output logic                       timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WARMUP  = 2'd1,
    S_MEASURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  localparam logic [MAX_CYCLE_WIDTH-1:0] CYCLE_MAX    = '1;
  localparam logic [MAX_CYCLE_WIDTH-1:0] WARMUP_LAST  = MAX_CYCLE_WIDTH'(WARMUP_CYCLES - 1);
  localparam logic [MAX_CYCLE_WIDTH-1:0] MEASURE_LAST = MAX_CYCLE_WIDTH'(MEASURE_CYCLES - 1);
`ifdef SIM_DRAIN_TIMEOUT_EN
  localparam logic [MAX_CYCLE_WIDTH-1:0] DRAIN_LAST   = MAX_CYCLE_WIDTH'(DRAIN_MAX_CYCLES - 1);
`endif
  localparam state_e FIRST_PHASE = (WARMUP_CYCLES == 0) ? S_MEASURE : S_WARMUP;

  state_e                     state_q, state_d;
  logic [MAX_CYCLE_WIDTH-1:0] current_cycle_q, current_cycle_d;
  logic [MAX_CYCLE_WIDTH-1:0] phase_cycle_q, phase_cycle_d;
  logic                       done_q, done_d;
  logic                       timeout_q, timeout_d;

  always_comb begin
    state_d         = state_q;
    current_cycle_d = current_cycle_q;
    phase_cycle_d   = phase_cycle_q;
    done_d          = 1'b0;
    timeout_d       = timeout_q;

    if (state_q == S_IDLE) begin
      if (start) begin
        state_d         = FIRST_PHASE;
        current_cycle_d = '0;
        phase_cycle_d   = '0;
        timeout_d       = 1'b0;
      end
    end else if (!pause) begin
      current_cycle_d = (current_cycle_q == CYCLE_MAX) ? current_cycle_q
                                                       : current_cycle_q + 1'b1;
      phase_cycle_d   = phase_cycle_q + 1'b1;
      case (state_q)
        S_WARMUP:  if (phase_cycle_q == WARMUP_LAST)  state_d = S_MEASURE;
        S_MEASURE: if (phase_cycle_q == MEASURE_LAST) state_d = S_DRAIN;
        S_DRAIN: begin
          // An empty network wins over a coincident timeout.
          if (network_empty) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            timeout_d = 1'b0;
          end
`ifdef SIM_DRAIN_TIMEOUT_EN
          else if (phase_cycle_q == DRAIN_LAST) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) phase_cycle_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      current_cycle_q <= '0;
      phase_cycle_q   <= '0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      current_cycle_q <= current_cycle_d;
      phase_cycle_q   <= phase_cycle_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
    end
  end

  assign state         = state_q;
  assign current_cycle = current_cycle_q;
  assign phase_cycle   = phase_cycle_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign inject_en     = ((state_q == S_WARMUP) || (state_q == S_MEASURE)) && !pause;
  assign measure_en    = (state_q == S_MEASURE) && !pause;

endmodule

// File: tb/tb_sim_run_controller.sv
// tb/tb_sim_run_controller.sv - directed table-driven bench for sim_run_controller
// Expectations follow SIM_DRAIN_TIMEOUT_EN when the macro is defined for the build.
module tb_sim_run_controller;

  logic clk = 1'b0;
  logic reset, start, pause, network_empty, start_sat, start_w0;

  logic [1:0] state, sat_state, w0_state;
  logic [4:0] current_cycle, phase_cycle, sat_cc, sat_ph, w0_cc, w0_ph;
  logic       inject_en, measure_en, done, timeout;
  logic       sat_inj, sat_meas, sat_done, sat_to;
  logic       w0_inj, w0_meas, w0_done, w0_to;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sim_run_controller u_dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .network_empty(network_empty),
    .state(state), .current_cycle(current_cycle), .phase_cycle(phase_cycle),
    .inject_en(inject_en), .measure_en(measure_en), .done(done), .timeout(timeout)
  );

  sim_run_controller #(.MEASURE_CYCLES(30)) u_sat (
    .clk(clk), .reset(reset), .start(start_sat), .pause(pause), .network_empty(network_empty),
    .state(sat_state), .current_cycle(sat_cc), .phase_cycle(sat_ph),
    .inject_en(sat_inj), .measure_en(sat_meas), .done(sat_done), .timeout(sat_to)
  );

  sim_run_controller #(.WARMUP_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .start(start_w0), .pause(pause), .network_empty(network_empty),
    .state(w0_state), .current_cycle(w0_cc), .phase_cycle(w0_ph),
    .inject_en(w0_inj), .measure_en(w0_meas), .done(w0_done), .timeout(w0_to)
  );

  typedef struct {
    logic       st, pa, em;
    int         n;
    logic [1:0] s;
    int         cc, ph;
    logic       inj, meas, dn, to;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic st, logic pa, logic em, int n, logic [1:0] s,
                              int cc, int ph, logic inj, logic meas, logic dn, logic to);
    vec_t v;
    v.st = st; v.pa = pa; v.em = em; v.n = n; v.s = s; v.cc = cc; v.ph = ph;
    v.inj = inj; v.meas = meas; v.dn = dn; v.to = to;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int s, input int cc, input int ph,
                          input int inj, input int meas, input int dn, input int to);
    chk({tag, ".state"}, int'(state), s);
    chk({tag, ".current_cycle"}, int'(current_cycle), cc);
    chk({tag, ".phase_cycle"}, int'(phase_cycle), ph);
    chk({tag, ".inject_en"}, int'(inject_en), inj);
    chk({tag, ".measure_en"}, int'(measure_en), meas);
    chk({tag, ".done"}, int'(done), dn);
    chk({tag, ".timeout"}, int'(timeout), to);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; network_empty = 1'b0;
    start_sat = 1'b0; start_w0 = 1'b0;

    //  st pa em  n  state cc  ph inj meas dn to
    add(0, 0, 0,  1, 2'd0,  0,  0, 0, 0, 0, 0);
    add(1, 0, 0,  1, 2'd1,  0,  0, 1, 0, 0, 0);
    add(0, 0, 0,  3, 2'd1,  3,  3, 1, 0, 0, 0);
    add(0, 0, 0,  1, 2'd2,  4,  0, 1, 1, 0, 0);
    add(0, 0, 0, 15, 2'd2, 19, 15, 1, 1, 0, 0);
    add(0, 0, 0,  1, 2'd3, 20,  0, 0, 0, 0, 0);
    add(0, 0, 0,  2, 2'd3, 22,  2, 0, 0, 0, 0);
    add(0, 0, 1,  1, 2'd0, 23,  0, 0, 0, 1, 0);
    add(0, 0, 0,  1, 2'd0, 23,  0, 0, 0, 0, 0);
    add(0, 1, 0,  2, 2'd0, 23,  0, 0, 0, 0, 0);
    add(1, 0, 0,  1, 2'd1,  0,  0, 1, 0, 0, 0);
    add(1, 0, 0,  1, 2'd1,  1,  1, 1, 0, 0, 0);
    add(0, 0, 0,  2, 2'd1,  3,  3, 1, 0, 0, 0);
    add(0, 0, 0,  1, 2'd2,  4,  0, 1, 1, 0, 0);
    add(0, 0, 0,  5, 2'd2,  9,  5, 1, 1, 0, 0);
    add(0, 1, 0,  3, 2'd2,  9,  5, 0, 0, 0, 0);
    add(0, 0, 0, 10, 2'd2, 19, 15, 1, 1, 0, 0);
    add(0, 0, 0,  1, 2'd3, 20,  0, 0, 0, 0, 0);

    step(2);
    chk_main("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; pause = tbl[i].pa; network_empty = tbl[i].em;
      step(tbl[i].n);
      chk_main($sformatf("vec%0d", i), tbl[i].s, tbl[i].cc, tbl[i].ph,
               tbl[i].inj, tbl[i].meas, tbl[i].dn, tbl[i].to);
    end
    start = 1'b0; pause = 1'b0; network_empty = 1'b0;

    step(7);
    chk_main("drain_last", 3, 27, 7, 0, 0, 0, 0);
`ifdef SIM_DRAIN_TIMEOUT_EN
    step(1);
    chk_main("timeout_exit", 0, 28, 0, 0, 0, 1, 1);
    step(1);
    chk_main("timeout_sticky", 0, 28, 0, 0, 0, 0, 1);
    start = 1'b1;
    step(1);
    chk_main("timeout_clear", 1, 0, 0, 1, 0, 0, 0);
    start = 1'b0;
    step(27);
    chk_main("tie_drain_last", 3, 27, 7, 0, 0, 0, 0);
    network_empty = 1'b1;
    step(1);
    chk_main("tie_empty_wins", 0, 28, 0, 0, 0, 1, 0);
    network_empty = 1'b0;
`else
    step(1);
    chk_main("no_timeout", 3, 28, 8, 0, 0, 0, 0);
    step(39);
    chk_main("drain_wait_sat", 3, 31, 15, 0, 0, 0, 0);
    network_empty = 1'b1; pause = 1'b1;
    step(2);
    chk_main("drain_paused_empty", 3, 31, 15, 0, 0, 0, 0);
    pause = 1'b0;
    step(1);
    chk_main("drain_empty_exit", 0, 31, 0, 0, 0, 1, 0);
    network_empty = 1'b0;
    step(1);
    chk_main("done_one_cycle", 0, 31, 0, 0, 0, 0, 0);
`endif

    start = 1'b1;
    step(1);
    chk_main("restart", 1, 0, 0, 1, 0, 0, 0);
    start = 1'b0;
    step(20);
    chk_main("restart_drain", 3, 20, 0, 0, 0, 0, 0);
    start = 1'b1; network_empty = 1'b1;
    step(1);
    chk_main("held_start_done", 0, 21, 0, 0, 0, 1, 0);
    step(1);
    chk_main("held_start_rerun", 1, 0, 0, 1, 0, 0, 0);
    start = 1'b0; network_empty = 1'b0;

    step(7);
    chk_main("pre_reset_measure", 2, 7, 3, 1, 1, 0, 0);
    reset = 1'b1;
    step(1);
    chk_main("mid_run_reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(1);
    chk_main("post_reset_idle", 0, 0, 0, 0, 0, 0, 0);

    start_sat = 1'b1;
    step(1);
    start_sat = 1'b0;
    chk("sat_start.state", int'(sat_state), 1);
    step(4);
    chk("sat_measure.state", int'(sat_state), 2);
    chk("sat_measure.cc", int'(sat_cc), 4);
    step(27);
    chk("sat_reach.cc", int'(sat_cc), 31);
    chk("sat_reach.ph", int'(sat_ph), 27);
    step(2);
    chk("sat_hold.state", int'(sat_state), 2);
    chk("sat_hold.cc", int'(sat_cc), 31);
    chk("sat_hold.ph", int'(sat_ph), 29);
    step(1);
    chk("sat_drain.state", int'(sat_state), 3);
    chk("sat_drain.cc", int'(sat_cc), 31);
    network_empty = 1'b1;
    step(1);
    chk("sat_done.state", int'(sat_state), 0);
    chk("sat_done.done", int'(sat_done), 1);
    network_empty = 1'b0;

    start_w0 = 1'b1;
    step(1);
    start_w0 = 1'b0;
    chk("w0_start.state", int'(w0_state), 2);
    chk("w0_start.cc", int'(w0_cc), 0);
    chk("w0_start.measure_en", int'(w0_meas), 1);
    step(16);
    chk("w0_drain.state", int'(w0_state), 3);
    chk("w0_drain.cc", int'(w0_cc), 16);
    network_empty = 1'b1;
    step(1);
    chk("w0_done.state", int'(w0_state), 0);
    chk("w0_done.done", int'(w0_done), 1);
    chk("w0_done.cc", int'(w0_cc), 17);
    network_empty = 1'b0;

    chk("main_idle_untouched", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
